dsp_result_buffer: RTL

- Downstream consumer of the pre-add/multiply/post-add DSP slice.
- Takes the slice's 48-bit P result plus a valid tag and optionally accumulates results into groups.
- Saturates each finished word to the output width and stores it in a small FIFO with a valid/ready output.
- Required because the DSP pipeline has no stall input. This block absorbs back-pressure and flags data loss.

---
 rtl/dsp_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 52 +++++
 rtl/dsp_result_buffer.sv | 80 ++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions: default slice widths and a signed saturation helper
// usable by any stage that narrows a wide signed value.
package dsp_pkg;

    localparam int DSP_P_W   = 48;
    localparam int DSP_OUT_W = 32;
    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic                        sat;
        logic signed [SAT_MAX_W-1:0] word;
    } sat_t;

    // Clamp value to the signed range of out_w bits; word comes back sign-extended.
    // Valid for 1 < out_w < SAT_MAX_W.
    function automatic sat_t sat_signed(input logic signed [SAT_MAX_W-1:0] value,
                                        input int out_w);
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        sat_t                        r;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            r.sat  = 1'b1;
            r.word = hi;
        end else if (value < lo) begin
            r.sat  = 1'b1;
            r.word = lo;
        end else begin
            r.sat  = 1'b0;
            r.word = value;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; level is the pointer difference.
// A push while full is accepted only when a pop frees the head in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_push;
    logic             w_pop;

    assign level  = r_wr - r_rd;
    assign empty  = (level == '0);
    assign full   = (level == (AW+1)'(DEPTH));
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    // Storage is not reset; rdata is forced to zero while empty instead.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
        end
    end

    assign rdata = empty ? '0 : r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/dsp_result_buffer.sv
// Accumulates/saturates DSP slice results and buffers them behind a valid/ready port.
// The slice cannot stall, so words arriving at a full buffer are dropped and flagged.
module dsp_result_buffer
    import dsp_pkg::*;
#(
    parameter int IN_W  = DSP_P_W,
    parameter int OUT_W = DSP_OUT_W,
    parameter int GUARD = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [IN_W-1:0]      in_data,
    input  logic                        in_last,
    input  logic                        mode_acc,
    output logic                        out_valid,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_sat,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow
);

    localparam int ACC_W = IN_W + GUARD;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_close;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_push;
    logic                    r_ovf;
    sat_t                    w_sat;
    logic                    w_unused_hi;

    assign w_sum   = r_acc + ACC_W'(in_data);
    // Pass-through mode closes every beat, folding in any leftover partial sum.
    assign w_close = in_valid & (~mode_acc | in_last);

    always_ff @(posedge clk) begin
        if (rst)
            r_acc <= '0;
        else if (in_valid)
            r_acc <= w_close ? '0 : w_sum;
    end

    assign w_sat       = sat_signed(SAT_MAX_W'(w_sum), OUT_W);
    assign w_unused_hi = ^w_sat.word[SAT_MAX_W-1:OUT_W];

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign w_push    = w_close & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (w_close & w_full & ~w_pop)
            r_ovf <= 1'b1;
    end

    assign overflow = r_ovf;

    sync_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({w_sat.sat, w_sat.word[OUT_W-1:0]}),
        .rdata ({out_sat, out_data}),
        .empty (w_empty),
        .full  (w_full),
        .level (level)
    );

endmodule
